// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: widths, opcode constants, fetch FSM states
// and the buffered-instruction payload.
package rv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_TYPE = 7'b0010011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and the
// decoded-instruction handshake toward control_unit.
interface fetch_unit_if;
   import rv_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [ILEN-1:0] imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic [ILEN-1:0] inst_out;
   logic [XLEN-1:0] inst_pc;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc,
      output inst_valid, inst_out, inst_pc, opcode, funct3, funct7,
      input  inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc,
      input  inst_valid, inst_out, inst_pc, opcode, funct3, funct7,
      output inst_ready
   );

endinterface

// File: rtl/fetch_unit_inst_buffer.sv
// Single-entry valid/ready holding register for one fetched {pc, inst};
// flush has priority over load and consume.
module inst_buffer
   import rv_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  fetch_entry_t i_entry,
   input  logic         i_flush,
   input  logic         i_ready,
   output logic         o_valid,
   output fetch_entry_t o_entry
);

   logic         r_valid;
   fetch_entry_t r_entry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_entry <= '{pc: '0, inst: INST_NOP};
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_entry <= i_entry;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_entry = r_entry;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding and
// hands one instruction at a time to decode. FETCH_MISALIGN_CHECK_EN adds a FAULT path.
module fetch_unit
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_unit_if.master  io_bus
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic          fetch_misalign
`endif
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_fetch_pc;
   logic            r_drop;
   logic            r_req_valid;

   logic            w_accept;
   logic            w_rsp;
   logic            w_in_flight;
   logic            w_stale;
   logic            w_load;
   logic            w_bad_target;
   logic [XLEN-1:0] w_target;
   logic            w_buf_valid;
   fetch_entry_t    w_entry;
   fetch_entry_t    w_buf;

   assign w_accept    = (r_state == REQ) & r_req_valid & io_bus.imem_req_ready;
   assign w_rsp       = io_bus.imem_rsp_valid;
   // A response is still owed to us after this edge; a redirect must discard it.
   assign w_in_flight = w_accept | ((r_state == WAIT) & ~w_rsp);
   assign w_stale     = w_in_flight | (r_drop & ~w_rsp);
   assign w_load      = (r_state == WAIT) & w_rsp & ~r_drop;
   assign w_target    = io_bus.redirect_pc & ~XLEN'(3);

`ifdef FETCH_MISALIGN_CHECK_EN
   logic r_misalign;

   assign w_bad_target = |io_bus.redirect_pc[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else if (io_bus.redirect_valid) begin
         r_misalign <= w_bad_target;
      end
   end

   assign fetch_misalign = r_misalign;
`else
   assign w_bad_target = 1'b0;
`endif

   // Fetch FSM; a redirect overrides whatever the current state would do.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= REQ;
         r_pc        <= RESET_PC;
         r_fetch_pc  <= '0;
         r_drop      <= 1'b0;
         r_req_valid <= 1'b0;
      end else if (io_bus.redirect_valid) begin
         r_drop <= w_stale;
         if (w_bad_target) begin
            r_state     <= FAULT;
            r_req_valid <= 1'b0;
         end else begin
            r_pc <= w_target;
            if (w_in_flight) begin
               r_state     <= WAIT;
               r_req_valid <= 1'b0;
            end else begin
               r_state     <= REQ;
               r_req_valid <= 1'b1;
            end
         end
      end else begin
         case (r_state)
            REQ: begin
               if (w_rsp) r_drop <= 1'b0;
               if (w_accept) begin
                  r_fetch_pc  <= r_pc;
                  r_pc        <= r_pc + XLEN'(4);
                  r_state     <= WAIT;
                  r_req_valid <= 1'b0;
               end else begin
                  r_req_valid <= 1'b1;
               end
            end
            WAIT: begin
               if (w_rsp) begin
                  r_drop      <= 1'b0;
                  r_state     <= r_drop ? REQ : HOLD;
                  r_req_valid <= r_drop;
               end
            end
            HOLD: begin
               if (io_bus.inst_ready) begin
                  r_state     <= REQ;
                  r_req_valid <= 1'b1;
               end
            end
            FAULT: begin
               if (w_rsp) r_drop <= 1'b0;
            end
            default: begin
               r_state     <= REQ;
               r_req_valid <= 1'b0;
            end
         endcase
      end
   end

   assign w_entry = '{pc: r_fetch_pc, inst: io_bus.imem_rsp_data};

   inst_buffer u_inst_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_entry (w_entry),
      .i_flush (io_bus.redirect_valid),
      .i_ready (io_bus.inst_ready),
      .o_valid (w_buf_valid),
      .o_entry (w_buf)
   );

   assign io_bus.imem_req_valid = r_req_valid;
   assign io_bus.imem_req_addr  = r_pc;
   assign io_bus.inst_valid     = w_buf_valid;
   assign io_bus.inst_out       = w_buf.inst;
   assign io_bus.inst_pc        = w_buf.pc;
   assign io_bus.opcode         = w_buf.inst[6:0];
   assign io_bus.funct3         = w_buf.inst[14:12];
   assign io_bus.funct7         = w_buf.inst[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit with a variable-latency imem
// model and a program-order scoreboard.
module tb_fetch_unit;
   import rv_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_unit_if bus ();

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fetch_misalign;
`endif

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .io_bus         (bus)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   int n_asrt = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Memory contents as a pure function of address; address 0 holds 0x00000093.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0000_0093 ^ (a << 5) ^ {a[15:2], 18'h0};
   endfunction

   // imem model: accepts on valid&ready, answers mem_lat cycles later.
   int          mem_lat;
   logic        acc_q;
   logic [31:0] acc_addr_q;
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_cnt;

   always @(posedge clk) begin
      acc_q      <= rst_n & bus.imem_req_valid & bus.imem_req_ready;
      acc_addr_q <= bus.imem_req_addr;
   end

   always @(negedge clk) begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (acc_q) begin
            chk("single_outstanding", 32'(pend), 32'd0);
            pend      = 1'b1;
            pend_addr = acc_addr_q;
            pend_cnt  = mem_lat;
         end
         if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
               bus.imem_rsp_valid = 1'b1;
               bus.imem_rsp_data  = mem_word(pend_addr);
               pend = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!bus.imem_req_valid && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.imem_req_valid), 32'd1);
   endtask

   task automatic wait_inst(input string tag);
      int n = 0;
      while (!bus.inst_valid && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.inst_valid), 32'd1);
   endtask

   task automatic consume();
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target, input logic also_ready);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      bus.inst_ready     = also_ready;
      tick();
      bus.redirect_valid = 1'b0;
      bus.inst_ready     = 1'b0;
   endtask

   // Scoreboard state for the random phase
   logic [31:0] exp_next;
   logic [31:0] old_inst;
   logic [31:0] old_pc;
   logic [31:0] rd_pc;
   logic [31:0] w;
   logic        rd;
   logic        held;
   int          n_deliv;

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1);
   end

   initial begin
      rst_n              = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.inst_ready     = 1'b0;
      mem_lat            = 1;
      n_deliv            = 0;

      // Reset values
      repeat (3) tick();
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst_out", bus.inst_out, 32'h0000_0013);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
      chk("rst_opcode", 32'(bus.opcode), 32'h13);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif

      // 1: first fetch with a 1-cycle memory
      rst_n = 1'b1;
      tick();
      chk("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("t1_req_addr", bus.imem_req_addr, 32'h0);
      tick();
      chk("t1_req_after_accept", 32'(bus.imem_req_valid), 32'd0);
      chk("t1_next_pc", bus.imem_req_addr, 32'h4);
      tick();
      chk("t1_inst_valid", 32'(bus.inst_valid), 32'd1);
      chk("t1_inst_out", bus.inst_out, 32'h0000_0093);
      chk("t1_inst_pc", bus.inst_pc, 32'h0);
      chk("t1_opcode", 32'(bus.opcode), 32'h13);
      chk("t1_funct3", 32'(bus.funct3), 32'h0);
      chk("t1_funct7", 32'(bus.funct7), 32'h0);

      // 2: decode stall holds everything
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t2_hold_valid", 32'(bus.inst_valid), 32'd1);
         chk("t2_hold_inst", bus.inst_out, 32'h0000_0093);
         chk("t2_hold_no_req", 32'(bus.imem_req_valid), 32'd0);
      end
      consume();
      chk("t2_consumed", 32'(bus.inst_valid), 32'd0);
      chk("t2_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("t2_req_addr", bus.imem_req_addr, 32'h4);
      wait_inst("t2_inst4_timeout");
      chk("t2_inst4_pc", bus.inst_pc, 32'h4);
      chk("t2_inst4_data", bus.inst_out, mem_word(32'h4));
      consume();

      // 3: redirect while waiting on a slow response for 0x8
      chk("t3_req_addr", bus.imem_req_addr, 32'h8);
      mem_lat = 3;
      tick();
      chk("t3_in_wait", 32'(bus.imem_req_valid), 32'd0);
      redirect(32'h100, 1'b0);
      chk("t3_no_inst", 32'(bus.inst_valid), 32'd0);
      chk("t3_still_wait", 32'(bus.imem_req_valid), 32'd0);
      wait_req("t3_req_timeout");
      mem_lat = 1;
      chk("t3_req_addr_redirect", bus.imem_req_addr, 32'h100);
      chk("t3_stale_dropped", 32'(bus.inst_valid), 32'd0);
      wait_inst("t3_inst_timeout");
      chk("t3_inst_pc", bus.inst_pc, 32'h100);
      chk("t3_inst_data", bus.inst_out, mem_word(32'h100));

      // 4: redirect wins over a same-cycle consume
      redirect(32'h40, 1'b1);
      chk("t4_flushed", 32'(bus.inst_valid), 32'd0);
      chk("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("t4_req_addr", bus.imem_req_addr, 32'h40);
      wait_inst("t4_inst_timeout");
      chk("t4_inst_pc", bus.inst_pc, 32'h40);
      chk("t4_inst_data", bus.inst_out, mem_word(32'h40));

      // 5: pc wraps at the top of the address space
      redirect(32'hFFFF_FFFC, 1'b0);
      chk("t5_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
      wait_inst("t5_inst_timeout");
      chk("t5_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
      consume();
      chk("t5_wrap_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("t5_wrap_addr", bus.imem_req_addr, 32'h0);

      // 6: misaligned redirect, issued while a request is being accepted
      redirect(32'h102, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("t6_misalign_set", 32'(fetch_misalign), 32'd1);
      chk("t6_no_inst", 32'(bus.inst_valid), 32'd0);
      for (int i = 0; i < 5; i++) begin
         chk("t6_fault_no_req", 32'(bus.imem_req_valid), 32'd0);
         chk("t6_fault_sticky", 32'(fetch_misalign), 32'd1);
         tick();
      end
      redirect(32'h200, 1'b0);
      chk("t6_misalign_clear", 32'(fetch_misalign), 32'd0);
      chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("t6_req_addr", bus.imem_req_addr, 32'h200);
      wait_inst("t6_inst_timeout");
      chk("t6_inst_pc", bus.inst_pc, 32'h200);
`else
      wait_req("t6_req_timeout");
      chk("t6_req_addr_aligned", bus.imem_req_addr, 32'h100);
      wait_inst("t6_inst_timeout");
      chk("t6_inst_pc", bus.inst_pc, 32'h100);
`endif
      consume();

      // Random phase: every delivered instruction follows program order from the
      // latest redirect target and carries that address's memory word.
      redirect(32'h1000, 1'b0);
      chk("rand_start_flush", 32'(bus.inst_valid), 32'd0);
      exp_next = 32'h1000;
      for (int i = 0; i < 3000; i++) begin
         bus.imem_req_ready = ($urandom_range(0, 9) < 7);
         mem_lat            = int'($urandom_range(1, 3));
         bus.inst_ready     = ($urandom_range(0, 9) < 6);
         rd                 = ($urandom_range(0, 99) < 4);
         rd_pc              = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
         rd_pc              = rd_pc & ~32'h3;
`endif
         bus.redirect_valid = rd;
         bus.redirect_pc    = rd_pc;
         held     = bus.inst_valid & ~bus.inst_ready & ~rd;
         old_inst = bus.inst_out;
         old_pc   = bus.inst_pc;
         tick();
         if (rd) begin
            exp_next = rd_pc & ~32'h3;
            chk("rand_redirect_flush", 32'(bus.inst_valid), 32'd0);
         end else if (held) begin
            chk("rand_hold_valid", 32'(bus.inst_valid), 32'd1);
            chk("rand_hold_inst", bus.inst_out, old_inst);
            chk("rand_hold_pc", bus.inst_pc, old_pc);
         end else if (bus.inst_valid) begin
            w = mem_word(exp_next);
            chk("rand_inst_pc", bus.inst_pc, exp_next);
            chk("rand_inst_out", bus.inst_out, w);
            chk("rand_opcode", 32'(bus.opcode), 32'(w[6:0]));
            chk("rand_funct3", 32'(bus.funct3), 32'(w[14:12]));
            chk("rand_funct7", 32'(bus.funct7), 32'(w[31:25]));
            exp_next = exp_next + 32'd4;
            n_deliv++;
         end
         chk("rand_no_req_while_valid", 32'(bus.imem_req_valid & bus.inst_valid), 32'd0);
      end
      bus.redirect_valid = 1'b0;
      bus.inst_ready     = 1'b0;
      chk("rand_progress", 32'(n_deliv > 100), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of control_unit.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Buffers one returned instruction and presents it to decode, with opcode/funct3/funct7 pre-sliced for control_unit.
- Accepts redirects (taken branch, JAL, JALR) from the execute/next-PC logic and flushes stale fetches.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response data valid (≥1 cycle after acceptance)
imem_rsp_data  in  32  fetched instruction word
redirect_valid  in  1  control-flow change (branch&branch_confirm | is_jal | is_jalr)
redirect_pc  in  XLEN  target address
inst_valid  out  1  buffered instruction valid to decode
inst_ready  in  1  decode consumes instruction
inst_out  out  32  buffered instruction
inst_pc  out  XLEN  address of inst_out
opcode  out  7  inst_out[6:0]
funct3  out  3  inst_out[14:12]
funct7  out  7  inst_out[31:25]

Behaviour:
- Reset (async assert, sync release) sets: state=REQ, pc=RESET_PC, imem_req_valid=0 during reset, inst_valid=0, inst_out=32'h0000_0013 (NOP), inst_pc=0, drop=0.
- imem_req_valid rises on the first clk edge after rst_n deasserts.
- FSM states:
  - REQ: imem_req_valid=1, imem_req_addr=pc. On valid&ready: fetch_pc<=pc, pc<=pc+4 (mod 2^XLEN, wraps 0xFFFF_FFFC→0), go to WAIT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid:
    - drop=0: capture inst_out<=rsp_data, inst_pc<=fetch_pc, inst_valid<=1, go to HOLD.
    - drop=1: discard the response, clear drop, go to REQ.
  - HOLD: inst_valid=1 and stable. On inst_ready: inst_valid<=0, go to REQ.
- Only one request is ever outstanding.
- Latency: acceptance → rsp_valid (memory-defined) → inst_valid one cycle later. Peak throughput is one instruction per 3 cycles with a 1-cycle memory.
- Redirect, in every state, sets pc<=redirect_pc next cycle:
  - REQ, not accepted: imem_req_addr changes to redirect_pc next cycle; imem is required to tolerate this.
  - REQ, accepted in the same cycle: request is in flight, so drop<=1 and go to WAIT.
  - WAIT: drop<=1. If rsp_valid arrives in the same cycle, the response is discarded, go to REQ, drop stays 0.
  - HOLD: inst_valid<=0, buffer discarded, go to REQ. This applies even if inst_ready is high in the same cycle (redirect wins).
- Back-to-back redirects: the last one wins. drop never exceeds one pending response.
- Decode stall (inst_ready=0) holds HOLD indefinitely; no new request is issued.
- Reset mid-WAIT: the late response is ignored because the state is REQ with imem_req_valid=0 until reset release. The memory must not deliver a response without a new acceptance.
- opcode/funct3/funct7 are purely combinational slices of inst_out.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined:
  - redirect_pc[1:0]!=0 moves the FSM to FAULT: no requests, inst_valid=0, output fetch_misalign (1 bit, port present only with the macro) =1.
  - FAULT persists until the next aligned redirect (→REQ, fetch_misalign=0) or reset.
  - An aligned redirect is processed normally.
- Undefined: redirect_pc[1:0] is forced to 2'b00 when loaded into pc; no fault state or port.

Decomposition:
- Shared package rv_pkg:
  - XLEN
  - opcode constants R_TYPE, I_TYPE, BRANCH, JAL, JALR, LUI, AUIPC
  - INST_NOP=32'h0000_0013
  - fetch_state_t enum {REQ, WAIT, HOLD, FAULT}
- One natural sub-module: inst_buffer. Single-entry valid/ready register holding {inst, pc}, with a flush input. fetch_unit keeps the FSM, pc and drop logic.

Test Plan:
1. Reset release, imem ready=1, 1-cycle response of 0x00000093 at addr 0 → req_addr 0x0 then 0x4; inst_valid with inst_out=0x00000093, inst_pc=0x0, opcode=7'b0010011.
2. inst_ready=0 for 10 cycles while HOLD → inst_valid/inst_out stable, imem_req_valid=0 throughout; release → next req_addr=0x4.
3. Redirect to 0x100 in WAIT for addr 0x8 → response for 0x8 dropped, no inst_valid for it; next req_addr=0x100, inst_pc=0x100.
4. Redirect 0x40 in HOLD with inst_ready=1 in the same cycle → instruction not consumed, inst_valid=0 next cycle, next req_addr=0x40.
5. pc=0xFFFF_FFFC accepted → next req_addr=0x0000_0000.
6. With FETCH_MISALIGN_CHECK_EN, redirect 0x102 → fetch_misalign=1, no requests; redirect 0x200 → fetch_misalign=0, req_addr=0x200. Without the macro: redirect 0x102 → req_addr=0x100.
